// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, synchronous imem requester and prefetch queue feeding decode over valid/ready.
// Ports: clk/rst (sync, active high); imem_en/imem_addr/imem_rdata (rdata one cycle after en);
// redirect/redirect_target (taken branch from MEM); out_ready/out_valid/out_pc4/out_instr (to IF/ID).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] pc, saved_pc4;
  logic inflight, pop, push;
  logic [AW-1:0] head, tail;
  logic [AW:0] count, occ;
  logic [31:0] q_pc4 [DEPTH];
  logic [31:0] q_instr [DEPTH];
  always_comb begin
    // occupancy counts the in-flight word so a returning read always has a free slot
    occ = count + {{AW{1'b0}}, inflight};
    out_valid = !rst && count != '0;
    pop = out_valid && out_ready && !redirect;
    push = inflight && !redirect;
    imem_en = !rst && !redirect && (occ < FULL || (occ == FULL && pop));
    imem_addr = pc;
    // gating by out_valid keeps never-written queue slots from leaking X to decode
    out_pc4 = out_valid ? q_pc4[head] : '0;
    out_instr = out_valid ? q_instr[head] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      saved_pc4 <= '0;
      inflight <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        pc <= pc + 32'd4;
        saved_pc4 <= pc + 32'd4;
      end
      if (redirect) begin
        pc <= redirect_target & ~32'h3;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc4[tail] <= saved_pc4;
      q_instr[tail] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard queue checked by an independent output monitor.
module tb_fetch_unit;
  logic clk = 0, rst = 1, imem_en, redirect = 0, out_ready = 0, out_valid;
  logic [31:0] imem_addr, imem_rdata = 0, redirect_target = 0, out_pc4, out_instr;
  logic [63:0] sb [$];
  int checks = 0, errors = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target), .out_ready(out_ready),
    .out_valid(out_valid), .out_pc4(out_pc4), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory: mem[a] = a + 0x100
  always @(posedge clk) if (imem_en) imem_rdata <= imem_addr + 32'h100;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc4, input logic [31:0] instr);
    sb.push_back({pc4, instr});
  endtask

  // leaves the bench in cycle 1 after release (rst=0, outputs settled)
  task automatic reset_dut();
    rst = 1;
    out_ready = 0;
    redirect = 0;
    step();
    check("rst_imem_en", 32'(imem_en), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_pc4", out_pc4, 0);
    check("rst_out_instr", out_instr, 0);
    step();
    rst = 0;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && !redirect && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got pc4=%h instr=%h expected nothing", out_pc4, out_instr);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({out_pc4, out_instr} !== e) begin
          errors++;
          $display("FAIL sb_pop: got pc4=%h instr=%h expected pc4=%h instr=%h",
                   out_pc4, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int issues;
    // reset then run: one instruction per cycle
    reset_dut();
    out_ready = 1;
    for (int i = 0; i < 6; i++) expect_word(32'(4 * i + 4), 32'(4 * i + 32'h100));
    for (int k = 1; k <= 8; k++) begin
      check("run_en", 32'(imem_en), 1);
      check("run_addr", imem_addr, 32'(4 * (k - 1)));
      if (k == 2) check("run_valid_c2", 32'(out_valid), 0);
      if (k == 3) check("run_valid_c3", 32'(out_valid), 1);
      step();
    end
    out_ready = 0;
    check("run_drained", 32'(sb.size()), 0);

    // stall fill: exactly DEPTH issues, head held, resume on first pop
    reset_dut();
    issues = 0;
    for (int k = 1; k <= 10; k++) begin
      if (imem_en) begin
        check("stall_addr", imem_addr, 32'(4 * issues));
        issues++;
      end
      step();
    end
    check("stall_issues", 32'(issues), 4);
    check("stall_en_off", 32'(imem_en), 0);
    check("stall_head_pc4", out_pc4, 32'h4);
    check("stall_head_instr", out_instr, 32'h100);
    for (int i = 0; i < 8; i++) expect_word(32'(4 * i + 4), 32'(4 * i + 32'h100));
    out_ready = 1;
    #1;
    check("resume_en", 32'(imem_en), 1);
    check("resume_addr", imem_addr, 32'h10);
    for (int i = 0; i < 8; i++) step();
    out_ready = 0;
    check("stall_drained", 32'(sb.size()), 0);

    // redirect with 3 queued + 1 in flight
    reset_dut();
    for (int i = 0; i < 4; i++) step();
    redirect = 1;
    redirect_target = 32'h0000_0203;
    out_ready = 1;
    #1;
    check("redir_en_off", 32'(imem_en), 0);
    expect_word(32'h204, 32'h300);
    expect_word(32'h208, 32'h304);
    expect_word(32'h20C, 32'h308);
    step();
    redirect = 0;
    #1;
    check("redir_valid_n1", 32'(out_valid), 0);
    check("redir_addr", imem_addr, 32'h200);
    step();
    check("redir_valid_n2", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) step();
    out_ready = 0;
    check("redir_drained", 32'(sb.size()), 0);

    // redirect while stalled and full
    reset_dut();
    for (int i = 0; i < 8; i++) step();
    check("full_en_off", 32'(imem_en), 0);
    check("full_valid", 32'(out_valid), 1);
    redirect = 1;
    redirect_target = 32'h40;
    #1;
    check("full_redir_en", 32'(imem_en), 0);
    expect_word(32'h44, 32'h140);
    expect_word(32'h48, 32'h144);
    step();
    redirect = 0;
    #1;
    check("full_redir_addr", imem_addr, 32'h40);
    check("full_redir_valid", 32'(out_valid), 0);
    step();
    check("full_redir_valid2", 32'(out_valid), 0);
    step();
    check("full_redir_valid3", 32'(out_valid), 1);
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    check("full_drained", 32'(sb.size()), 0);

    // PC wrap
    reset_dut();
    redirect = 1;
    redirect_target = 32'hFFFF_FFFC;
    expect_word(32'h0, 32'hFC);
    expect_word(32'h4, 32'h100);
    step();
    redirect = 0;
    #1;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", imem_addr, 32'h0);
    step();
    out_ready = 1;
    step();
    step();
    out_ready = 0;
    check("wrap_drained", 32'(sb.size()), 0);

    // reset mid-run with two queued entries
    reset_dut();
    for (int i = 0; i < 3; i++) step();
    check("mid_valid_pre", 32'(out_valid), 1);
    rst = 1;
    #1;
    check("mid_rst_en", 32'(imem_en), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    step();
    check("mid_rst_valid2", 32'(out_valid), 0);
    check("mid_rst_pc4", out_pc4, 0);
    rst = 0;
    #1;
    check("mid_restart_en", 32'(imem_en), 1);
    check("mid_restart_addr", imem_addr, 32'h0);
    expect_word(32'h4, 32'h100);
    expect_word(32'h8, 32'h104);
    out_ready = 1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 0;
    check("mid_drained", 32'(sb.size()), 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
